// File: rtl/accum_seq_ctrl.sv
// accum_seq_ctrl: command-driven sequencer for the step-accumulator datapath (optional repeat mode: SEQ_REPEAT_EN)
module accum_seq_ctrl #(
    parameter int STEP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [STEP_W-1:0] n_steps,
    input  logic [STEP_W-1:0] tap_a,
    input  logic [STEP_W-1:0] tap_b,
    input  logic              hold,
    input  logic              abort,
    input  logic              auto_rpt,
    output logic              busy,
    output logic              done,
    output logic              acc_clr,
    output logic              acc_en,
    output logic [STEP_W-1:0] step,
    output logic              load_a,
    output logic              load_b
);
    typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;
    state_t state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d, n_q, n_d, ta_q, ta_d, tb_q, tb_d;
    logic load_a_q, load_a_d, load_b_q, load_b_d, rpt_q, rpt_d, run_en, last, again;
    assign run_en  = state_q == RUN && !hold && !abort;
    assign last    = step_q == n_q - STEP_W'(1);
    assign busy    = state_q != IDLE;
    assign done    = state_q == DONE;
    assign acc_clr = state_q == CLEAR;
    assign acc_en  = run_en;
    assign step    = step_q;
    assign load_a  = load_a_q;
    assign load_b  = load_b_q;
`ifdef SEQ_REPEAT_EN
    assign again = rpt_q;
`else
    logic unused_rpt;
    assign unused_rpt = rpt_q;
    assign again = 1'b0;
`endif
    // next state, step counter, latched command fields and strobe set-up
    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        n_d      = n_q;
        ta_d     = ta_q;
        tb_d     = tb_q;
        rpt_d    = rpt_q;
        load_a_d = run_en && step_q == ta_q;
        load_b_d = run_en && step_q == tb_q;
        if (state_q == IDLE) begin
            if (start) begin
                state_d = CLEAR;
                step_d  = '0;
                n_d     = n_steps;
                ta_d    = tap_a;
                tb_d    = tap_b;
                rpt_d   = auto_rpt;
            end
        end else if (abort) begin
            state_d = IDLE;
            step_d  = '0;
        end else if (state_q == CLEAR) begin
            state_d = n_q == '0 ? DONE : RUN;
            step_d  = '0;
        end else if (state_q == RUN) begin
            if (!hold) begin
                state_d = last ? DONE : RUN;
                step_d  = last ? '0 : step_q + STEP_W'(1);
            end
        end else begin
            state_d = again ? CLEAR : IDLE;
        end
    end
    // state and datapath-facing registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            step_q   <= '0;
            n_q      <= '0;
            ta_q     <= '0;
            tb_q     <= '0;
            rpt_q    <= 1'b0;
            load_a_q <= 1'b0;
            load_b_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            n_q      <= n_d;
            ta_q     <= ta_d;
            tb_q     <= tb_d;
            rpt_q    <= rpt_d;
            load_a_q <= load_a_d;
            load_b_q <= load_b_d;
        end
    end
endmodule

// File: tb/tb_accum_seq_ctrl.sv
// tb_accum_seq_ctrl: randomized and directed checks of accum_seq_ctrl against a command-level model
module tb_accum_seq_ctrl;
    localparam bit REP =
`ifdef SEQ_REPEAT_EN
        1'b1;
`else
        1'b0;
`endif
    logic clk = 0, rst = 1, start = 0, hold = 0, abort = 0, auto_rpt = 0;
    logic [7:0] n_steps = 0, tap_a = 0, tap_b = 0, step;
    logic busy, done, acc_clr, acc_en, load_a, load_b;
    int pass_n = 0, tot_n = 0, cyc = 0;
    // model: position within the command, -1 = clear, 0..n-1 = steps, n = done
    bit m_act = 0, m_rpt = 0, m_la = 0, m_lb = 0, mvalid = 0;
    int m_pos = 0, m_n = 0, m_ta = 0, m_tb = 0;
    int w = 0, pa = 0, pb = 0;
    int t0 = 0, clr_c, la_c, lb_c, done_c, bf_c, la_n, lb_n, done_n, en_n, busy_n;
    bit seen_busy;

    accum_seq_ctrl #(.STEP_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .n_steps(n_steps), .tap_a(tap_a), .tap_b(tap_b),
        .hold(hold), .abort(abort), .auto_rpt(auto_rpt), .busy(busy), .done(done),
        .acc_clr(acc_clr), .acc_en(acc_en), .step(step), .load_a(load_a), .load_b(load_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // datapath stand-in driven by the DUT strobes, to see what ports A and B would capture
    always @(posedge clk) begin
        if (acc_clr) w <= 0;
        else if (acc_en) w <= w + int'(step);
        if (load_a) pa <= w;
        if (load_b) pb <= w;
    end

    // command-level reference model
    always @(posedge clk) begin
        bit en;
        en = m_act && m_pos >= 0 && m_pos < m_n && !hold && !abort;
        if (rst) begin
            m_act = 0; m_pos = 0; m_la = 0; m_lb = 0; mvalid = 1;
        end else begin
            m_la = en && m_pos == m_ta;
            m_lb = en && m_pos == m_tb;
            if (!m_act) begin
                if (start) begin
                    m_act = 1; m_pos = -1; m_n = n_steps; m_ta = tap_a; m_tb = tap_b; m_rpt = auto_rpt;
                end
            end else if (abort) m_act = 0;
            else if (m_pos < m_n) m_pos += (m_pos < 0 || !hold) ? 1 : 0;
            else begin
                m_act = REP && m_rpt; m_pos = -1;
            end
        end
    end

    task automatic chk(string nm, int act, int exp);
        tot_n++;
        if (act == exp) pass_n++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic tick();
        @(negedge clk);
        if (start && !busy && !rst) begin
            t0 = cyc; clr_c = -1; la_c = -1; lb_c = -1; done_c = -1; bf_c = -1;
            la_n = 0; lb_n = 0; done_n = 0; en_n = 0; busy_n = 0; seen_busy = 0;
        end
        if (acc_clr && clr_c < 0) clr_c = cyc - t0;
        if (load_a) begin la_n++; if (la_c < 0) la_c = cyc - t0; end
        if (load_b) begin lb_n++; if (lb_c < 0) lb_c = cyc - t0; end
        if (done) begin done_n++; if (done_c < 0) done_c = cyc - t0; end
        if (acc_en) en_n++;
        if (busy) begin busy_n++; seen_busy = 1; end
        else if (seen_busy && bf_c < 0) bf_c = cyc - t0;
        if (mvalid) begin
            chk("busy", busy, m_act);
            chk("done", done, m_act && m_pos == m_n);
            chk("acc_clr", acc_clr, m_act && m_pos == -1);
            chk("acc_en", acc_en, m_act && m_pos >= 0 && m_pos < m_n && !hold && !abort);
            chk("load_a", load_a, m_la);
            chk("load_b", load_b, m_lb);
            if (m_act && m_pos < m_n) chk("step", step, m_pos < 0 ? 0 : m_pos);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(int k);
        for (int i = 0; i < k; i++) tick();
    endtask

    task automatic go(int n, int ta, int tb, bit r);
        start = 1; n_steps = 8'(n); tap_a = 8'(ta); tap_b = 8'(tb); auto_rpt = r;
        tick();
        start = 0;
    endtask

    initial begin
        run(2);
        rst = 0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_clr", acc_clr, 0);
        chk("rst_en", acc_en, 0);
        chk("rst_step", step, 0);
        chk("rst_loads", {load_a, load_b}, 0);
        run(2);
        go(21, 10, 20, 0);
        run(26);
        chk("s1_clr_cycle", clr_c, 1);
        chk("s1_load_a_cycle", la_c, 13);
        chk("s1_port_a", pa, 55);
        chk("s1_load_b_cycle", lb_c, 23);
        chk("s1_done_cycle", done_c, 23);
        chk("s1_port_b", pb, 210);
        chk("s1_busy_fall", bf_c, 24);
        go(0, 0, 0, 0);
        run(4);
        chk("s2_done_cycle", done_c, 2);
        chk("s2_acc_en_count", en_n, 0);
        go(5, 2, 2, 0);
        for (int k = 1; k <= 12; k++) begin
            hold = k >= 3 && k <= 5;
            tick();
        end
        hold = 0;
        chk("s3_load_a_cycle", la_c, 8);
        chk("s3_load_b_cycle", lb_c, 8);
        chk("s3_done_cycle", done_c, 10);
        chk("s3_acc_en_count", en_n, 5);
        go(8, 5, 6, 0);
        run(5);
        abort = 1;
        tick();
        abort = 0;
        chk("s4_busy_after_abort", busy, 0);
        chk("s4_done_count", done_n, 0);
        chk("s4_load_count", la_n + lb_n, 0);
        go(3, 0, 1, 0);
        run(6);
        chk("s4_restart_clr", clr_c, 1);
        chk("s4_restart_done", done_c, 5);
        go(4, 1, 3, 0);
        run(2);
        start = 1; n_steps = 9; tap_a = 0; tap_b = 0;
        tick();
        start = 0;
        run(2);
        start = 1;
        tick();
        start = 0;
        run(3);
        chk("s5_done_count", done_n, 1);
        chk("s5_done_cycle", done_c, 6);
        chk("s5_load_a_cycle", la_c, 4);
        chk("s5_load_b_cycle", lb_c, 6);
        chk("s5_busy_fall", bf_c, 7);
        go(3, 0, 0, 1);
        run(12);
        abort = 1;
        tick();
        abort = 0;
        run(2);
        chk("s6_done_count", done_n, REP ? 2 : 1);
        chk("s6_busy_cycles", busy_n, REP ? 13 : 5);
        chk("s6_busy_fall", bf_c, REP ? 14 : 6);
        go(10, 3, 4, 0);
        run(4);
        rst = 1;
        tick();
        rst = 0;
        chk("s7_busy_after_rst", busy, 0);
        run(3);
        chk("s7_done_count", done_n, 0);
        for (int i = 0; i < 2500; i++) begin
            start = $urandom_range(0, 3) == 0;
            n_steps = 8'($urandom_range(0, 20));
            tap_a = 8'($urandom_range(0, 22));
            tap_b = $urandom_range(0, 3) == 0 ? tap_a : 8'($urandom_range(0, 22));
            auto_rpt = $urandom_range(0, 3) == 0;
            hold = $urandom_range(0, 4) == 0;
            abort = $urandom_range(0, 30) == 0;
            rst = $urandom_range(0, 150) == 0;
            tick();
        end
        {start, hold, abort, rst} = 0;
        run(3);
        $display("%0d/%0d checks passed", pass_n, tot_n);
        $finish;
    end
endmodule

// File: doc/accum_seq_ctrl.md
# accum_seq_ctrl

Sequencing controller for the team's step-accumulator datapath (W register, adder W + step, capture ports A and B). On a start command it clears the accumulator, then steps an internal counter from 0 to N-1 and enables accumulation each step. It fires capture strobes for ports A and B at programmable step taps and reports completion. It replaces hard-wired compare logic in the datapath and runs it as a command-driven engine.

## Interface

Parameters:
- STEP_W, 8, width of step counter, n_steps and taps

Ports (reset rst, synchronous, active-high; clock clk):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  command request, accepted only in IDLE
- n_steps  in  STEP_W  number of accumulate steps, sampled with start
- tap_a  in  STEP_W  step index whose result is captured to port A, sampled with start
- tap_b  in  STEP_W  step index whose result is captured to port B, sampled with start
- hold  in  1  pause stepping while in RUN
- abort  in  1  cancel the current command
- auto_rpt  in  1  repeat request, sampled with start (see Configuration)
- busy  out  1  high in CLEAR, RUN and DONE
- done  out  1  one-cycle completion pulse
- acc_clr  out  1  datapath: W <= 0
- acc_en  out  1  datapath: W <= W + step
- step  out  STEP_W  current step value, fed to the datapath adder
- load_a  out  1  datapath: port A <= W
- load_b  out  1  datapath: port B <= W

## Operation

- FSM states: IDLE, CLEAR, RUN, DONE.
- IDLE to CLEAR on start. Latch n_steps, tap_a, tap_b and auto_rpt.
- CLEAR lasts one cycle. acc_clr=1 and step=0.
  - Go to DONE if the latched n_steps==0.
  - Otherwise go to RUN.
- RUN:
  - acc_en = !hold. step increments by 1 after each enabled cycle.
  - With hold=1, step and the state are frozen.
  - Leave for DONE after the enabled cycle with step==n_steps-1.
- DONE lasts one cycle with done=1. Next state is IDLE, or CLEAR when repeating (see Configuration).
- Capture strobes:
  - load_a is registered. It is set in the cycle after an enabled RUN cycle with step==tap_a, so port A captures the sum 0..tap_a.
  - load_b follows the same rule with tap_b.
  - A tap >= n_steps never fires.
  - tap_a==tap_b fires both strobes in the same cycle.
  - A strobe pending on the last step appears in the DONE cycle.
- Abort in any non-IDLE state:
  - Next state is IDLE.
  - No done pulse.
  - Pending strobes are cancelled.
  - acc_en=0 in the abort cycle.
- Abort takes priority over hold, and hold over stepping.
- start outside IDLE is ignored, including in the DONE cycle.
- The step counter does not wrap within a command, because n_steps <= 2^STEP_W - 1.
- acc_clr, acc_en, busy and done decode from registered state. step, load_a and load_b are registers.

## Timing

- Reset values: state IDLE; busy, done, acc_clr, acc_en, load_a, load_b = 0; step = 0; latched fields = 0.
- rst takes precedence over all inputs. Reset mid-command returns to IDLE in one cycle with no done pulse.
- Run timeline (start sampled in cycle 0, no hold):
  - CLEAR in cycle 1.
  - RUN in cycles 2..N+1, with step=0..N-1.
  - DONE in cycle N+2.
  - IDLE in cycle N+3.
- Latency from start to done: N+2 cycles, plus one cycle per held cycle.
- Latency from the tap step to its load strobe: 1 cycle.
- Next start is accepted in cycle N+3 at the earliest.

## Configuration

- SEQ_REPEAT_EN defined:
  - In DONE with latched auto_rpt=1, the next state is CLEAR instead of IDLE, and the command re-runs with the same latched fields.
  - done pulses once per pass, and busy stays high.
  - Only abort or rst exits repeat mode.
- SEQ_REPEAT_EN undefined:
  - The auto_rpt port remains but is ignored.
  - DONE always goes to IDLE.

## Test plan

- start with n_steps=21, tap_a=10, tap_b=20 -> acc_clr in cycle 1. load_a in cycle 13, so port A = 55. load_b and done together in cycle 23, so port B = 210. busy falls in cycle 24.
- n_steps=0 -> CLEAR then DONE. acc_en never asserts; done in cycle 2.
- n_steps=5, tap_a=tap_b=2, hold high for 3 cycles at step 1 -> step frozen at 1 and acc_en=0 for those cycles. load_a and load_b fire together. done in cycle 10.
- n_steps=8, abort during step 4 -> IDLE the next cycle. No done pulse; no load strobes for taps 5 or 6. start is accepted again immediately afterwards.
- start pulsed during RUN, and again in the DONE cycle -> both ignored; latched fields unchanged.
- With SEQ_REPEAT_EN, auto_rpt=1, n_steps=3 -> done pulses every 5 cycles and busy stays high. After abort, busy=0 within 1 cycle. Without SEQ_REPEAT_EN -> a single done pulse, then IDLE.
